mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: holds MAR/MDR and sequences fixed-length read/write accesses
// through an Idle -> Access -> Done state machine driving active-low memory strobes.
module mem_access_unit #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Bus_in,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        Mem_req,
    input  logic        Mem_wr,
    input  logic [15:0] Mem_rdata,
    output logic [15:0] Mem_addr,
    output logic [15:0] Mem_wdata,
    output logic        Mem_CE_n,
    output logic        Mem_OE_n,
    output logic        Mem_WE_n,
    output logic [15:0] MDR_out,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    // Counter value during the final strobe cycle of an access.
    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;

    logic last_cycle;
    assign last_cycle = (cnt_q == LastCnt);

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Mem_req) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (last_cycle) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mar_q <= 16'h0000;
            mdr_q <= 16'h0000;
            cnt_q <= 4'd0;
            wr_q  <= 1'b0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
        end
    end

    // MAR/MDR only accept bus loads while idle; a load coinciding with a request
    // is what the new access uses, since the registers update at the same edge.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        cnt_d = cnt_q;
        wr_d  = wr_q;
        unique case (state_q)
            StIdle: begin
                if (LD_MAR) begin
                    mar_d = Bus_in;
                end
                if (LD_MDR) begin
                    mdr_d = Bus_in;
                end
                if (Mem_req) begin
                    wr_d  = Mem_wr;
                    cnt_d = 4'd0;
                end
            end
            StAccess: begin
                if (last_cycle) begin
                    if (!wr_q) begin
                        mdr_d = Mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs decode from the state register so an async reset releases strobes at once.
    always_comb begin
        Busy     = 1'b0;
        Done     = 1'b0;
        Mem_CE_n = 1'b1;
        Mem_OE_n = 1'b1;
        Mem_WE_n = 1'b1;
        unique case (state_q)
            StAccess: begin
                Busy     = 1'b1;
                Mem_CE_n = 1'b0;
                Mem_OE_n = wr_q;
                Mem_WE_n = ~wr_q;
            end
            StDone: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign Mem_addr  = mar_q;
    assign Mem_wdata = mdr_q;
    assign MDR_out   = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (WAIT_CYCLES=2 and 1) share stimulus and are
// compared every cycle against a cycles-remaining reference model.
module tb_mem_access_unit;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] Bus_in;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        Mem_req;
    logic        Mem_wr;
    logic [15:0] Mem_rdata;

    logic [15:0] addr_o  [2];
    logic [15:0] wdata_o [2];
    logic [15:0] mdr_o   [2];
    logic        ce_n_o  [2];
    logic        oe_n_o  [2];
    logic        we_n_o  [2];
    logic        busy_o  [2];
    logic        done_o  [2];

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: access length per instance, and remaining strobe cycles.
    int unsigned ws     [2] = '{2, 1};
    int unsigned m_left [2];
    bit          m_done [2];
    bit          m_wr   [2];
    logic [15:0] m_mar  [2];
    logic [15:0] m_mdr  [2];

    mem_access_unit #(.WAIT_CYCLES(2)) u_dut2 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Bus_in    (Bus_in),
        .LD_MAR    (LD_MAR),
        .LD_MDR    (LD_MDR),
        .Mem_req   (Mem_req),
        .Mem_wr    (Mem_wr),
        .Mem_rdata (Mem_rdata),
        .Mem_addr  (addr_o[0]),
        .Mem_wdata (wdata_o[0]),
        .Mem_CE_n  (ce_n_o[0]),
        .Mem_OE_n  (oe_n_o[0]),
        .Mem_WE_n  (we_n_o[0]),
        .MDR_out   (mdr_o[0]),
        .Busy      (busy_o[0]),
        .Done      (done_o[0])
    );

    mem_access_unit #(.WAIT_CYCLES(1)) u_dut1 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Bus_in    (Bus_in),
        .LD_MAR    (LD_MAR),
        .LD_MDR    (LD_MDR),
        .Mem_req   (Mem_req),
        .Mem_wr    (Mem_wr),
        .Mem_rdata (Mem_rdata),
        .Mem_addr  (addr_o[1]),
        .Mem_wdata (wdata_o[1]),
        .Mem_CE_n  (ce_n_o[1]),
        .Mem_OE_n  (oe_n_o[1]),
        .Mem_WE_n  (we_n_o[1]),
        .MDR_out   (mdr_o[1]),
        .Busy      (busy_o[1]),
        .Done      (done_o[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0;
            m_done[i] = 1'b0;
            m_wr[i]   = 1'b0;
            m_mar[i]  = 16'h0000;
            m_mdr[i]  = 16'h0000;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_done[i]) begin
                m_done[i] = 1'b0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (!m_wr[i]) m_mdr[i] = Mem_rdata;
                    m_done[i] = 1'b1;
                end
            end else begin
                if (LD_MAR) m_mar[i] = Bus_in;
                if (LD_MDR) m_mdr[i] = Bus_in;
                if (Mem_req) begin
                    m_wr[i]   = Mem_wr;
                    m_left[i] = ws[i];
                end
            end
        end
    endtask

    task automatic check_all();
        logic bsy;
        for (int i = 0; i < 2; i++) begin
            bsy = (m_left[i] > 0);
            chk($sformatf("addr[%0d]", i),  addr_o[i],  m_mar[i]);
            chk($sformatf("wdata[%0d]", i), wdata_o[i], m_mdr[i]);
            chk($sformatf("mdr[%0d]", i),   mdr_o[i],   m_mdr[i]);
            chk($sformatf("busy[%0d]", i),  16'(busy_o[i]), 16'(bsy));
            chk($sformatf("done[%0d]", i),  16'(done_o[i]), 16'(m_done[i]));
            chk($sformatf("ce_n[%0d]", i),  16'(ce_n_o[i]), 16'(!bsy));
            chk($sformatf("oe_n[%0d]", i),  16'(oe_n_o[i]), 16'(!(bsy && !m_wr[i])));
            chk($sformatf("we_n[%0d]", i),  16'(we_n_o[i]), 16'(!(bsy && m_wr[i])));
            chk($sformatf("oe_we_excl[%0d]", i), 16'(oe_n_o[i] | we_n_o[i]), 16'd1);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        if (!Reset_n) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        LD_MAR  = 1'b0;
        LD_MDR  = 1'b0;
        Mem_req = 1'b0;
        Mem_wr  = 1'b0;
    endtask

    int dones;

    initial begin
        Reset_n   = 1'b0;
        Bus_in    = 16'h0000;
        Mem_rdata = 16'h0000;
        idle_inputs();
        model_reset();
        #12;
        check_all();
        Reset_n = 1'b1;

        // Read 0x3000, memory returns 0xBEEF
        Bus_in = 16'h3000;
        LD_MAR = 1'b1;
        step();
        idle_inputs();
        Mem_req   = 1'b1;
        Mem_rdata = 16'hBEEF;
        step();
        Mem_req = 1'b0;
        chk("rd_addr", addr_o[0], 16'h3000);
        chk("rd_oe_c1", 16'(oe_n_o[0]), 16'd0);
        step();
        chk("rd_oe_c2", 16'(oe_n_o[0]), 16'd0);
        step();
        chk("rd_done_c3", 16'(done_o[0]), 16'd1);
        chk("rd_mdr", mdr_o[0], 16'hBEEF);
        step();
        step();

        // Load MAR/MDR and write in the same cycle
        Bus_in  = 16'h1234;
        LD_MAR  = 1'b1;
        LD_MDR  = 1'b1;
        Mem_req = 1'b1;
        Mem_wr  = 1'b1;
        Mem_rdata = 16'h5A5A;
        step();
        idle_inputs();
        Bus_in = 16'h0000;
        chk("wr_addr", addr_o[0], 16'h1234);
        chk("wr_wdata", wdata_o[0], 16'h1234);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done_o[0]) dones++;
        end
        chk("wr_done_once", 16'(dones), 16'd1);

        // LD_MAR during an access is ignored
        Mem_req = 1'b1;
        Mem_rdata = 16'h7777;
        step();
        Mem_req = 1'b0;
        Bus_in  = 16'hFFFF;
        LD_MAR  = 1'b1;
        step();
        LD_MAR = 1'b0;
        chk("frozen_mar", addr_o[0], 16'h1234);
        step();
        step();
        step();

        // Request held through Done is not taken until Idle
        Mem_req = 1'b1;
        Mem_wr  = 1'b0;
        for (int k = 0; k < 9; k++) step();
        idle_inputs();
        for (int k = 0; k < 4; k++) step();

        // Back-to-back requests: W=1 instance completes every 3 cycles
        Mem_req = 1'b1;
        dones = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (done_o[1]) dones++;
        end
        chk("b2b_dones", 16'(dones), 16'd3);
        idle_inputs();
        for (int k = 0; k < 4; k++) step();

        // Reset in the second access cycle
        Bus_in = 16'h4321;
        LD_MAR = 1'b1;
        LD_MDR = 1'b1;
        Mem_req = 1'b1;
        step();
        idle_inputs();
        step();
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_ce_n", 16'(ce_n_o[0]), 16'd1);
        chk("rst_mar", addr_o[0], 16'h0000);
        step();
        #3;
        Reset_n = 1'b1;
        step();
        step();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            Bus_in    = 16'($urandom);
            Mem_rdata = 16'($urandom);
            LD_MAR    = ($urandom_range(0, 3) == 0);
            LD_MDR    = ($urandom_range(0, 3) == 0);
            Mem_req   = ($urandom_range(0, 2) == 0);
            Mem_wr    = 1'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
